// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - nibble stream in, program-memory write port out
interface program_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [3:0]        in_nibble;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // loader side: consumes the nibble stream and drives the memory write port
  modport slave (
    input  in_valid,
    input  in_nibble,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  // host side: produces the nibble stream and observes the memory write port
  modport master (
    output in_valid,
    output in_nibble,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed nibble-stream loader into writable program memory
module program_loader #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LEN2  = 4'd1;
  localparam logic [3:0] S_LEN1  = 4'd2;
  localparam logic [3:0] S_LEN0  = 4'd3;
  localparam logic [3:0] S_HI    = 4'd4;
  localparam logic [3:0] S_LO    = 4'd5;
  localparam logic [3:0] S_WRITE = 4'd6;
  localparam logic [3:0] S_CHECK = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_ERR   = 4'd9;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [3:0]  state;
  logic [11:0] length;
  logic [11:0] count;
  logic [11:0] count_next;
  logic [3:0]  csum;
  logic [3:0]  hi_nib;
  logic        xfer;

  assign xfer       = bus.in_valid & bus.in_ready;
  assign count_next = count + 12'd1;

  // decode handshake, write strobe and status straight from the state
  always_comb begin
    bus.in_ready = 1'b0;
    case (state)
      S_LEN2, S_LEN1, S_LEN0, S_HI, S_LO, S_CHECK: bus.in_ready = 1'b1;
      default:                                      bus.in_ready = 1'b0;
    endcase
    bus.mem_we = (state == S_WRITE);
    busy       = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    // the processor stays in reset exactly while a load is in flight
    cpu_hold   = busy;
  end

  // load sequencer: header, byte assembly, memory write, checksum verdict
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      length        <= '0;
      count         <= '0;
      csum          <= '0;
      hi_nib        <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.mem_addr  <= BASE;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN2;
            done         <= 1'b0;
            err          <= 1'b0;
            csum         <= '0;
            count        <= '0;
            bus.mem_addr <= BASE;
          end
        end
        S_LEN2: if (xfer) begin
          length[11:8] <= bus.in_nibble;
          state        <= S_LEN1;
        end
        S_LEN1: if (xfer) begin
          length[7:4] <= bus.in_nibble;
          state       <= S_LEN0;
        end
        S_LEN0: if (xfer) begin
          length[3:0] <= bus.in_nibble;
          // an empty program goes straight to the checksum nibble
          state       <= ({length[11:4], bus.in_nibble} == 12'd0) ? S_CHECK : S_HI;
        end
        S_HI: if (xfer) begin
          hi_nib <= bus.in_nibble;
          csum   <= csum ^ bus.in_nibble;
          state  <= S_LO;
        end
        S_LO: if (xfer) begin
          bus.mem_wdata <= {hi_nib, bus.in_nibble};
          csum          <= csum ^ bus.in_nibble;
          state         <= S_WRITE;
        end
        S_WRITE: begin
          // address wraps naturally at 2^ADDR_W; a long program is not an error
          bus.mem_addr <= bus.mem_addr + 1'b1;
          count        <= count_next;
          state        <= (count_next == length) ? S_CHECK : S_HI;
        end
        S_CHECK: if (xfer) begin
          if (bus.in_nibble == csum) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
